// File: rtl/jk_counter_pkg.sv
// Shared constants and the J/K excitation helper for the JK-cell counter family.
package jk_counter_pkg;

  localparam int unsigned WidthMin = 2;
  localparam int unsigned WidthMax = 16;

  // Command encoded as {J,K}
  typedef enum logic [1:0] {
    HOLD   = 2'b00,
    RESET  = 2'b01,
    SET    = 2'b10,
    TOGGLE = 2'b11
  } jk_cmd_e;

  // Load forces the cell to din; otherwise a counting bit toggles when its T term is set.
  function automatic jk_cmd_e jk_excite(logic load, logic d, logic en, logic t);
    if (load) return d ? SET : RESET;
    return (en && t) ? TOGGLE : HOLD;
  endfunction

endpackage

// File: rtl/jk_sync_counter_if.sv
// Control/status bundle between a counter user (master) and jk_sync_counter (slave).
interface jk_sync_counter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] q;
  logic             tc;

  modport master (output en, up, load, din, input q, tc);
  modport slave  (input en, up, load, din, output q, tc);
endinterface

// File: rtl/jk_cell.sv
// Single JK flip-flop bit with asynchronous active-high clear.
module jk_cell (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  logic q_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= 1'b0;
    end else begin
      q_q <= (j & ~q_q) | (~k & q_q);
    end
  end

  assign q = q_q;

endmodule

// File: rtl/jk_sync_counter.sv
// Synchronous up/down counter with parallel load built from jk_cell bits.
// Optional build macro COUNTER_SAT_EN: saturate at the terminal count instead of wrapping.
module jk_sync_counter
  import jk_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input logic               clk,
  input logic               rst,
  jk_sync_counter_if.slave  bus
);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] t;
  logic             tc;
  jk_cmd_e          cmd [WIDTH];

  // Bit i toggles when all lower bits are 1 (up) or all 0 (down).
  always_comb begin
    logic run;
    t   = '0;
    run = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      t[i] = run;
      run  = run & (bus.up ? q[i] : ~q[i]);
    end
`ifdef COUNTER_SAT_EN
    if (tc) t = '0;
`endif
  end

  always_comb begin
    tc = bus.en & (bus.up ? (&q) : ~(|q));
  end

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      cmd[i] = jk_excite(bus.load, bus.din[i], bus.en, t[i]);
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell u_cell (
      .clk (clk),
      .rst (rst),
      .j   (cmd[i][1]),
      .k   (cmd[i][0]),
      .q   (q[i])
    );
  end

  assign bus.q  = q;
  assign bus.tc = tc;

endmodule

// File: tb/tb_jk_sync_counter.sv
// Randomised plus directed bench for jk_sync_counter against an arithmetic reference model.
module tb_jk_sync_counter;

  localparam int unsigned W    = 4;
  localparam int unsigned MASK = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  jk_sync_counter_if #(.WIDTH(W)) bus ();

  jk_sync_counter #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int unsigned model_q;
  int          n_vec  = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_vec++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int unsigned exp_tc();
    if (!bus.en) return 0;
    if (bus.up) return (model_q == MASK) ? 1 : 0;
    return (model_q == 0) ? 1 : 0;
  endfunction

  function automatic int unsigned next_q(int unsigned cur);
    bit sat;
`ifdef COUNTER_SAT_EN
    sat = 1'b1;
`else
    sat = 1'b0;
`endif
    if (bus.load) return int'(bus.din);
    if (!bus.en) return cur;
    if (sat && exp_tc() == 1) return cur;
    if (bus.up) return (cur + 1) & MASK;
    return (cur + MASK) & MASK;
  endfunction

  // One rising edge: advance the model from the pre-edge inputs, then compare.
  task automatic tick(input string tag);
    int unsigned nq;
    nq = rst ? 0 : next_q(model_q);
    @(posedge clk);
    model_q = nq;
    #1;
    check({tag, ".q"}, int'(bus.q), model_q);
    check({tag, ".tc"}, int'(bus.tc), exp_tc());
  endtask

  task automatic drive(input bit en, input bit up, input bit load, input int unsigned din);
    bus.en   = en;
    bus.up   = up;
    bus.load = load;
    bus.din  = din[W-1:0];
  endtask

  initial begin
    model_q = 0;
    drive(0, 1, 0, 0);
    #12;
    check("reset.q", int'(bus.q), 0);
    bus.up = 1'b0;
    bus.en = 1'b1;
    #1;
    check("reset.tc", int'(bus.tc), 1);
    @(negedge clk);
    rst = 1'b0;

    // Async reset mid-count at 9, a pending load must be discarded
    drive(0, 1, 1, 9);
    tick("ld9");
    check("ld9.const", int'(bus.q), 9);
    drive(1, 1, 1, 4'hC);
    @(negedge clk);
    #2;
    rst = 1'b1;
    model_q = 0;
    #1;
    check("async_rst.q", int'(bus.q), 0);
    check("async_rst.tc", int'(bus.tc), exp_tc());
    tick("rst_hold");
    @(negedge clk);
    rst = 1'b0;
    drive(1, 1, 0, 0);
    tick("rst_rel");
    check("rst_rel.const", int'(bus.q), 1);

    // Up wrap from 0 over 17 edges
    drive(0, 1, 1, 0);
    tick("ld0");
    drive(1, 1, 0, 0);
    for (int i = 0; i < 17; i++) tick("upwrap");

    // Down wrap from 2
    drive(0, 0, 1, 2);
    tick("ld2");
    drive(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick("dnwrap");

    // Load beats count
    drive(0, 1, 1, 5);
    tick("ld5");
    drive(1, 1, 1, 4'hA);
    tick("ldprio");
    check("ldprio.const", int'(bus.q), 4'hA);
    drive(1, 1, 0, 0);
    tick("after_ld");

    // Hold at 7, then alternate direction
    drive(0, 1, 1, 7);
    tick("ld7");
    drive(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) tick("hold");
    for (int i = 0; i < 4; i++) begin
      drive(1, (i % 2) == 0, 0, 0);
      tick("dirchg");
    end

    // Terminal-count behaviour (saturate or wrap depending on build)
    drive(0, 1, 1, 4'hE);
    tick("ldE");
    drive(1, 1, 0, 0);
    for (int i = 0; i < 3; i++) tick("top");
    drive(0, 0, 1, 1);
    tick("ld1");
    drive(1, 0, 0, 0);
    for (int i = 0; i < 2; i++) tick("bottom");

    // Random traffic, including occasional reset pulses
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(3, 0) != 0, $urandom_range(1, 0) == 1,
            $urandom_range(7, 0) == 0, $urandom_range(MASK, 0));
      rst = ($urandom_range(31, 0) == 0);
      if (rst) begin
        #1;
        model_q = 0;
        check("rnd_rst.q", int'(bus.q), 0);
      end
      tick("rnd");
      rst = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
